// File: rtl/floor_request_arbiter.sv
// Floor request arbiter: sync/debounce buttons, hold pending
// requests and pick the next target floor for the car FSM.
// Optional feature macro: REQ_COUNT_EN adds served_count.

module fra_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [7:0] LAST = 8'(DB_CYCLES - 1);

  logic       s1_q;
  logic       s2_q;
  logic       db_q;
  logic       db_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // count consecutive differing samples; any match clears
  always_comb begin
    db_d  = db_q;
    cnt_d = 8'd0;
    if (s2_q != db_q) begin
      if (cnt_q == LAST) begin
        db_d  = ~db_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // two-flop synchroniser and debounce state
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = db_q;

endmodule

module floor_request_arbiter #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_g,
  input  logic       btn_f,
  input  logic       btn_s,
  input  logic       btn_emerg,
  input  logic [1:0] cur_floor,
  input  logic       arrived,
  output logic       g_f,
  output logic       f_f,
  output logic       s_f,
  output logic       emerg_in,
`ifdef REQ_COUNT_EN
  output logic [7:0] served_count,
`endif
  output logic [2:0] pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    EMERG = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] db_lvl;
  logic [2:0] db_prev_q;
  logic       emg_lvl;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] tgt_q;
  logic [2:0] tgt_d;
  logic       emg_q;
  logic [1:0] floor;
  logic [2:0] cur_oh;
  logic [2:0] above;
  logic [2:0] below;
  logic [2:0] up_set;
  logic [2:0] dn_set;
  logic [2:0] rise;
  logic [2:0] set_req;

  fra_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_g (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_g),
    .level_o(db_lvl[0])
  );

  fra_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_f (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_f),
    .level_o(db_lvl[1])
  );

  fra_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_s),
    .level_o(db_lvl[2])
  );

  fra_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_e (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_emerg),
    .level_o(emg_lvl)
  );

  // position decode; illegal floor 3 behaves as ground
  always_comb begin
    floor = (cur_floor == 2'd3) ? 2'd0 : cur_floor;
    unique case (floor)
      2'd1: begin
        cur_oh = 3'b010;
        above  = 3'b100;
        below  = 3'b001;
      end
      2'd2: begin
        cur_oh = 3'b100;
        above  = 3'b000;
        below  = 3'b011;
      end
      default: begin
        cur_oh = 3'b001;
        above  = 3'b110;
        below  = 3'b000;
      end
    endcase
    up_set = pend_q & above;
    dn_set = pend_q & below;
  end

  // request bitmap: set on press, arrival clear wins
  always_comb begin
    rise    = db_lvl & ~db_prev_q;
    set_req = rise;
    if (state_q == IDLE)
      set_req = set_req & ~cur_oh;
    pend_d = pend_q | set_req;
    if (arrived)
      pend_d = pend_d & ~cur_oh;
    if (emg_lvl || state_q == EMERG)
      pend_d = 3'b000;
  end

  // direction selection, up preferred when both exist
  always_comb begin
    state_d = state_q;
    if (emg_lvl) begin
      state_d = EMERG;
    end else begin
      unique case (state_q)
        EMERG: state_d = IDLE;
        DOWN: begin
          if (|dn_set)      state_d = DOWN;
          else if (|up_set) state_d = UP;
          else              state_d = IDLE;
        end
        default: begin
          if (|up_set)      state_d = UP;
          else if (|dn_set) state_d = DOWN;
          else              state_d = IDLE;
        end
      endcase
    end
  end

  // nearest pending floor in the chosen direction
  always_comb begin
    tgt_d = 3'b000;
    unique case (state_d)
      UP: begin
        if (up_set[0])      tgt_d = 3'b001;
        else if (up_set[1]) tgt_d = 3'b010;
        else if (up_set[2]) tgt_d = 3'b100;
      end
      DOWN: begin
        if (dn_set[2])      tgt_d = 3'b100;
        else if (dn_set[1]) tgt_d = 3'b010;
        else if (dn_set[0]) tgt_d = 3'b001;
      end
      default: tgt_d = 3'b000;
    endcase
  end

  // state, requests and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 3'b000;
      tgt_q     <= 3'b000;
      db_prev_q <= 3'b000;
      emg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
      db_prev_q <= db_lvl;
      emg_q     <= emg_lvl;
    end
  end

`ifdef REQ_COUNT_EN
  logic [7:0] cnt_q;

  // saturating count of arrivals that retire a request
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 8'd0;
    else if (arrived && |(pend_q & cur_oh) && cnt_q != 8'd255)
      cnt_q <= cnt_q + 8'd1;
  end

  assign served_count = cnt_q;
`endif

  assign g_f      = tgt_q[0];
  assign f_f      = tgt_q[1];
  assign s_f      = tgt_q[2];
  assign pending  = pend_q;
  assign emerg_in = emg_q;

endmodule
